huff_next_code_gen: RTL

//  Canonical-Huffman code assigner; sits directly downstream of the 16x9 bit-length count array.

---
 rtl/huff_pkg.sv | 21 ++
 rtl/huff_next_code_rf.sv | 48 ++++
 rtl/huff_next_code_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the canonical-Huffman next-code generator:
// code-length limits, field widths, FSM state encoding and the Kraft target.
package huff_pkg;

    localparam int MAX_BL = 15;
    localparam int CNT_W  = 9;
    localparam int CODE_W = MAX_BL;
    localparam int ACC_W  = 16;

    localparam logic [3:0]       K_LAST     = 4'(MAX_BL);
    localparam logic [ACC_W-1:0] KRAFT_FULL = ACC_W'(1 << MAX_BL);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
        CHECK,
        READY
    } state_t;

endpackage

// File: rtl/huff_next_code_rf.sv
// next_code[1..MAX_BL] register file: one write port for the build walk,
// one increment port for code assignment, async read (addr 0 reads 0).
// Ports: clk, rstN, wr_en/wr_addr/wr_data, inc_en/inc_addr, rd_addr/rd_data.
module huff_next_code_rf
    import huff_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic              inc_en,
    input  logic [3:0]        inc_addr,
    input  logic [3:0]        rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

    logic [ACC_W-1:0] regs [1:MAX_BL];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 1; i <= MAX_BL; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= MAX_BL; i++) begin
                if (wr_en && (wr_addr == 4'(i))) begin
                    regs[i] <= wr_data;
                end else if (inc_en && (inc_addr == 4'(i))) begin
                    regs[i] <= regs[i] + ONE;
                end
            end
        end
    end

    // Emitted codes are the low CODE_W bits; the top bit only carries.
    always_comb begin
        rd_data = '0;
        for (int i = 1; i <= MAX_BL; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_data = regs[i][CODE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/huff_next_code_gen.sv
// Canonical-Huffman code assigner: walks the bit-length count array to
// build next_code[], checks the Kraft sum, then hands out one code per request.
// Ports: clk, rstN, start; count-array aux port bl_addr/bl_busy/bl_count;
// ready, kraft_err; request len_vld/len; response code_vld/code/code_len.
module huff_next_code_gen
    import huff_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              bl_busy,
    output logic [3:0]        bl_addr,
    input  logic [CNT_W-1:0]  bl_count,
    output logic              ready,
    output logic              kraft_err,
    input  logic              len_vld,
    input  logic [3:0]        len,
    output logic              code_vld,
    output logic [CODE_W-1:0] code,
    output logic [3:0]        code_len
);

    state_t           state;
    state_t           state_d;
    logic [3:0]       k;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             one_l1;

    logic [ACC_W-1:0]  sum_now;
    logic [ACC_W-1:0]  nxt_code;
    logic              cap_wr;
    logic              req_ok;
    logic              rf_wr_en;
    logic [3:0]        rf_wr_addr;
    logic [ACC_W-1:0]  rf_wr_data;
    logic              rf_inc_en;
    logic [CODE_W-1:0] rf_rd_data;

    assign sum_now  = acc + ACC_W'(bl_count);
    assign nxt_code = {sum_now[ACC_W-2:0], 1'b0};
    assign cap_wr   = (state == CAPT) && (k != K_LAST);
    assign req_ok   = len_vld && (state == READY) && !start;

    assign bl_addr = k;
    assign ready   = (state == READY);

    // start seeds next_code[1]=0; each capture writes next_code[k+1].
    assign rf_wr_en   = start || cap_wr;
    assign rf_wr_addr = start ? 4'd1 : k + 4'd1;
    assign rf_wr_data = start ? '0 : nxt_code;
    assign rf_inc_en  = req_ok && (len != 4'd0);

    huff_next_code_rf u_rf (
        .clk      (clk),
        .rstN     (rstN),
        .wr_en    (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_data  (rf_wr_data),
        .inc_en   (rf_inc_en),
        .inc_addr (len),
        .rd_addr  (len),
        .rd_data  (rf_rd_data)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    ;
            ISSUE:   if (!bl_busy) state_d = CAPT;
            CAPT:    state_d = (k == K_LAST) ? CHECK : ISSUE;
            CHECK:   state_d = READY;
            READY:   ;
            default: state_d = IDLE;
        endcase
        if (start) state_d = ISSUE;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            k         <= '0;
            acc       <= '0;
            sum       <= '0;
            one_l1    <= 1'b0;
            kraft_err <= 1'b0;
        end else if (start) begin
            k         <= 4'd1;
            acc       <= '0;
            one_l1    <= 1'b0;
            kraft_err <= 1'b0;
        end else begin
            unique case (state)
                CAPT: begin
                    if (k != K_LAST) begin
                        acc <= nxt_code;
                        k   <= k + 4'd1;
                    end else begin
                        sum <= sum_now;
                    end
                    // Track "exactly one code, of length 1" (legal, sum != full).
                    if (k == 4'd1) begin
                        one_l1 <= (bl_count == CNT_W'(1));
                    end else if (bl_count != '0) begin
                        one_l1 <= 1'b0;
                    end
                end
                CHECK: begin
                    kraft_err <= (sum != KRAFT_FULL) && (sum != '0) && !one_l1;
                end
                default: ;
            endcase
        end
    end

    // Table is incremented on the same edge the code is captured, so
    // back-to-back requests for one length see consecutive values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            code_vld <= 1'b0;
            code     <= '0;
            code_len <= '0;
        end else begin
            code_vld <= req_ok;
            if (req_ok) begin
                code     <= (len == 4'd0) ? '0 : rf_rd_data;
                code_len <= len;
            end
        end
    end

endmodule
